// File: rtl/avr_cpu_writeback.sv
// AVR execute-to-writeback stage: one-entry pending register in front of
// the 32x8 register file and SREG, with combinational read/SREG bypass.

// One bypassed register-file read port. The pending entry shadows the file
// until it commits, so readers never see a stale value.
module avr_wb_rd_port (
  input  logic [4:0]       addr,
  input  logic [31:0][7:0] rf,
  input  logic             pend_valid,
  input  logic [4:0]       pend_rd,
  input  logic [7:0]       pend_out,
  input  logic [7:0]       pend_hi,
  input  logic             pend_wr_reg,
  input  logic             pend_wr_pair,
  output logic [7:0]       data
);

  // Pair hits select lo/hi by address LSB; single hits need an exact match.
  always_comb begin
    data = rf[addr];
    if (pend_valid) begin
      if (pend_wr_pair) begin
        if (addr[4:1] == pend_rd[4:1]) data = addr[0] ? pend_hi : pend_out;
      end else if (pend_wr_reg && (addr == pend_rd)) begin
        data = pend_out;
      end
    end
  end

endmodule

module avr_cpu_writeback #(
  parameter logic [7:0] SREG_RESET = 8'h00,
  parameter logic [7:0] REG_RESET  = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       stall,
  input  logic       alu_valid,
  input  logic [4:0] alu_rd,
  input  logic [7:0] alu_out,
  input  logic [7:0] alu_status,
  input  logic       alu_wr_reg,
  input  logic       alu_wr_pair,
  input  logic [7:0] alu_hi,
  input  logic [7:0] alu_flag_mask,
  input  logic       io_sreg_we,
  input  logic [7:0] io_sreg_wdata,
  input  logic       irq_ack,
  input  logic       reti,
  input  logic [4:0] rd_addr_a,
  input  logic [4:0] rd_addr_b,
  output logic [7:0] rd_data_a,
  output logic [7:0] rd_data_b,
  output logic [7:0] sreg,
  output logic [7:0] sreg_q,
  output logic       wb_busy
);

  localparam int NUM_RD = 2;

  typedef struct packed {
    logic [4:0] rd;
    logic [7:0] out;
    logic [7:0] hi;
    logic [7:0] status;
    logic [7:0] mask;
    logic       wr_reg;
    logic       wr_pair;
  } wb_ent_t;

  logic                   pend_valid;
  wb_ent_t                pend;
  logic [31:0][7:0]       rf;
  logic [7:0]             sreg_nxt;
  logic                   commit;
  logic [NUM_RD-1:0][4:0] rd_addr;
  logic [NUM_RD-1:0][7:0] rd_data;

  assign commit  = !stall && pend_valid;
  assign wb_busy = pend_valid;

  // Capture: a new entry replaces the one committing on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend       <= '0;
    end else if (!stall) begin
      pend_valid <= alu_valid;
      if (alu_valid) begin
        pend.rd      <= alu_rd;
        pend.out     <= alu_out;
        pend.hi      <= alu_hi;
        pend.status  <= alu_status;
        pend.mask    <= alu_flag_mask;
        pend.wr_reg  <= alu_wr_reg;
        pend.wr_pair <= alu_wr_pair;
      end
    end
  end

  // Register-file commit; pair writes win over single writes and force an even base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf <= {32{REG_RESET}};
    end else if (commit) begin
      if (pend.wr_pair) begin
        rf[{pend.rd[4:1], 1'b0}] <= pend.out;
        rf[{pend.rd[4:1], 1'b1}] <= pend.hi;
      end else if (pend.wr_reg) begin
        rf[pend.rd] <= pend.out;
      end
    end
  end

  // SREG next value, lowest priority source first so later ones override.
  // io/irq/reti are independent of stall.
  always_comb begin
    sreg_nxt = sreg_q;
    if (commit)     sreg_nxt = (pend.mask & pend.status) | (~pend.mask & sreg_q);
    if (io_sreg_we) sreg_nxt = io_sreg_wdata;
    if (reti)       sreg_nxt[7] = 1'b1;
    if (irq_ack)    sreg_nxt[7] = 1'b0;
  end

  // Architectural SREG register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sreg_q <= SREG_RESET;
    else        sreg_q <= sreg_nxt;
  end

  // Effective SREG seen by the ALU: pending flags override committed ones.
  always_comb begin
    sreg = sreg_q;
    if (pend_valid) sreg = (pend.mask & pend.status) | (~pend.mask & sreg_q);
  end

  assign rd_addr[0] = rd_addr_a;
  assign rd_addr[1] = rd_addr_b;
  assign rd_data_a  = rd_data[0];
  assign rd_data_b  = rd_data[1];

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    avr_wb_rd_port u_rd (
      .addr         (rd_addr[p]),
      .rf           (rf),
      .pend_valid   (pend_valid),
      .pend_rd      (pend.rd),
      .pend_out     (pend.out),
      .pend_hi      (pend.hi),
      .pend_wr_reg  (pend.wr_reg),
      .pend_wr_pair (pend.wr_pair),
      .data         (rd_data[p])
    );
  end

endmodule

// File: doc/avr_cpu_writeback.md
Name: avr_cpu_writeback

Overview:
Execute-to-writeback pipeline stage directly downstream of the AVR ALU. It latches the ALU result, status flags and destination into a one-entry writeback register, then commits them to the 32x8 general register file and to SREG. It drives the register-file read ports with bypass from the pending entry. It also drives the status_in value the ALU consumes, so back-to-back ADC/SBC/CPC chains see up-to-date flags.

Parameters:
SREG_RESET, 8'h00, SREG value loaded on reset.
REG_RESET, 8'h00, value loaded into every general register on reset.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
stall  in  1  hold: no new capture, no commit, pending entry retained.
alu_valid  in  1  ALU result presented this cycle.
alu_rd  in  5  destination register index.
alu_out  in  8  ALU result byte.
alu_status  in  8  ALU status_out.
alu_wr_reg  in  1  commit alu_out to rd.
alu_wr_pair  in  1  commit {alu_hi, alu_out} to r[rd+1]:r[rd] (MOVW/ADIW/MUL); rd[0] ignored, treated as 0.
alu_hi  in  8  high byte for pair write.
alu_flag_mask  in  8  per-bit SREG update enable; 1 = take alu_status bit.
io_sreg_we  in  1  OUT/STS to SREG (I/O 0x3F).
io_sreg_wdata  in  8  SREG write data.
irq_ack  in  1  interrupt taken: clear I (bit 7).
reti  in  1  RETI executed: set I.
rd_addr_a  in  5  read port A address.
rd_addr_b  in  5  read port B address.
rd_data_a  out  8  read port A data, combinational, bypassed.
rd_data_b  out  8  read port B data, combinational, bypassed.
sreg  out  8  effective SREG, bypassed; feeds ALU status_in.
sreg_q  out  8  architectural SREG register (committed only).
wb_busy  out  1  pending entry valid.

Behaviour:
- Reset (async, rst_n low): pend_valid=0, pending fields=0, SREG=SREG_RESET, all 32 registers=REG_RESET; wb_busy=0, sreg=sreg_q=SREG_RESET.
- Stage 1, capture: on a clock edge with stall=0, pend_valid<=alu_valid. When alu_valid=1, also latch rd, out, hi, status, mask, wr_reg and wr_pair.
- Stage 2, commit: on the edge with stall=0 and pend_valid=1, apply the pending entry:
  - Registers: wr_pair has priority over wr_reg. wr_pair writes r[{rd[4:1],0}]=out and r[{rd[4:1],1}]=hi. Otherwise wr_reg writes r[rd]=out.
  - SREG: for each bit i with mask[i]=1, SREG[i]<=status[i].
- Capture and commit happen on the same edge: the new entry replaces the committed one. Latency is 1 cycle from alu_valid to pending and 2 edges to the architectural state.
- stall=1: pending entry held, nothing committed. Outputs keep bypassing the held entry.
- SREG write priority, same edge, highest first:
  1. irq_ack clears bit 7.
  2. reti sets bit 7.
  3. io_sreg_we loads io_sreg_wdata on all bits.
  4. Pending ALU mask update.
  - Bits not claimed by a higher source fall through to the next source.
  - irq_ack and reti together: irq_ack wins.
  - io_sreg_we, irq_ack and reti act even when stall=1.
- Read bypass, combinational:
  - rd_data_x = pending out when pend_valid & wr_reg & !wr_pair & addr==rd.
  - rd_data_x = pending out or hi when pend_valid & wr_pair and the address matches the even or odd register of the pair.
  - Otherwise rd_data_x = regfile[addr].
- sreg output: bitwise (mask & status) | (~mask & sreg_q) when pend_valid, else sreg_q. Same-cycle io/irq/reti are not bypassed; they are visible next cycle.
- No flag arithmetic is done here. Z-chaining for CPC/SBC is already resolved by the ALU from status_in.
- Reset asserted mid-pipeline discards the pending entry; nothing commits.

Test Plan:
- Reset with SREG_RESET=8'h80 -> sreg=sreg_q=8'h80, wb_busy=0, rd_data_a for every address = 8'h00.
- Writeback of alu_valid, rd=16, out=8'h5A, wr_reg=1, mask=8'h3F, status=8'h02 -> next cycle rd_data_a(addr 16)=8'h5A via bypass and sreg=8'h02; after a further edge with no new entry, regfile[16]=8'h5A and sreg_q=8'h02.
- Back-to-back ADC chain: first entry status C=1, mask=8'h3F -> on the following cycle sreg[0]=1 is presented to the ALU without waiting for commit.
- Pair write with rd=25, out=8'h34, hi=8'h12, wr_pair=1 -> r24=8'h34, r25=8'h12. Bypass on both addresses 24 and 25 during the pending cycle.
- Stall: hold stall=1 for 3 cycles with a pending entry -> regfile unchanged, bypass still active, wb_busy=1. Release -> commit occurs on the first edge.
- Priority on one edge: irq_ack=1, io_sreg_we=1 with 8'hFF, pending mask=8'hFF, status=8'h00 -> SREG=8'h7F. Repeat with reti=1 and irq_ack=1 -> bit7=0.
